// File: rtl/mcu_debug_responder_pkg.sv
// Shared types and helpers for the MCU debug responder.
//   state_e     : responder FSM states
//   op_e        : latched debug operation
//   prio_encode : strobe priority encoder (reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd)
//   be_is_onehot: true when exactly one byte enable is set
//   be_mask     : expands 4 byte enables into a 32-bit lane mask
package dbg_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_PAUSED  = 3'd1,
    S_DRAIN   = 3'd2,
    S_ACC_MEM = 3'd3,
    S_ACC_RF  = 3'd4,
    S_RESET   = 3'd5,
    S_ACK     = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_PAUSE  = 3'd0,
    OP_RESUME = 3'd1,
    OP_RESET  = 3'd2,
    OP_MEM_WR = 3'd3,
    OP_MEM_RD = 3'd4,
    OP_RF_WR  = 3'd5,
    OP_RF_RD  = 3'd6,
    OP_NONE   = 3'd7
  } op_e;

  function automatic op_e prio_encode(
    input logic reset,
    input logic pause,
    input logic resume,
    input logic mem_wr,
    input logic mem_rd,
    input logic rf_wr,
    input logic rf_rd
  );
    op_e op;
    if (reset) begin
      op = OP_RESET;
    end else if (pause) begin
      op = OP_PAUSE;
    end else if (resume) begin
      op = OP_RESUME;
    end else if (mem_wr) begin
      op = OP_MEM_WR;
    end else if (mem_rd) begin
      op = OP_MEM_RD;
    end else if (rf_wr) begin
      op = OP_RF_WR;
    end else if (rf_rd) begin
      op = OP_RF_RD;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  function automatic logic be_is_onehot(input logic [3:0] be);
    return (be != 4'b0000) && ((be & (be - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mcu_debug_responder_rdata_align.sv
// Read-data lane alignment for debug memory reads.
//   be   : latched byte enables of the read command
//   word : 32-bit word returned by memory
//   data : one-hot be -> selected byte zero-extended; otherwise word AND lane mask
module dbg_rdata_align
  import dbg_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [31:0] word,
  output logic [31:0] data
);

  // Select and zero-extend a single byte lane, or mask the whole word.
  always_comb begin
    data = word & be_mask(be);
    case (be)
      4'b0001: data = {24'h00_0000, word[7:0]};
      4'b0010: data = {24'h00_0000, word[15:8]};
      4'b0100: data = {24'h00_0000, word[23:16]};
      4'b1000: data = {24'h00_0000, word[31:24]};
      default: data = word & be_mask(be);
    endcase
  end

endmodule

// File: rtl/mcu_debug_responder.sv
// MCU-side endpoint of the debugger command interface.
//   Command side : in_valid + level-held strobes (pause/resume/reset/rf_rd/rf_wr/mem_rd/mem_wr),
//                  mem_be, addr, wdata; returns mcu_busy and rdata.
//   Core side    : core_halt, core_reset out; core_idle in.
//   Reg file     : dbg_rf_addr/wdata/we out; dbg_rf_rdata in (combinational).
//   Memory port  : dbg_mem_addr/wdata/be/we/rd out; dbg_mem_rdata in (MEM_RD_LAT cycles after rd).
// All outputs come straight from flops.
module mcu_debug_responder
  import dbg_pkg::*;
#(
  parameter int MEM_RD_LAT    = 1,
  parameter int RST_CYCLES    = 4,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        rf_rd,
  input  logic        rf_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mcu_busy,
  output logic [31:0] rdata,
  output logic        core_halt,
  output logic        core_reset,
  input  logic        core_idle,
  output logic [4:0]  dbg_rf_addr,
  output logic [31:0] dbg_rf_wdata,
  output logic        dbg_rf_we,
  input  logic [31:0] dbg_rf_rdata,
  output logic [31:0] dbg_mem_addr,
  output logic [31:0] dbg_mem_wdata,
  output logic [3:0]  dbg_mem_be,
  output logic        dbg_mem_we,
  output logic        dbg_mem_rd,
  input  logic [31:0] dbg_mem_rdata
);

  localparam int CW = $clog2(MEM_RD_LAT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] LAT_C      = CW'(MEM_RD_LAT);
  localparam logic [RW-1:0] RST_LAST_C = RW'(RST_CYCLES - 1);

  state_e        state_r, state_nxt;
  op_e           op_r, op_enc_s, op_eff_s;
  logic          paused_r, paused_nxt;
  logic          armed_r, armed_nxt;
  logic [CW-1:0] lat_cnt_r, lat_cnt_nxt;
  logic [RW-1:0] rst_cnt_r, rst_cnt_nxt;
  logic [31:0]   addr_r, wdata_r, mem_wdata_r, rdata_r, rdata_nxt;
  logic [3:0]    be_r;
  logic [4:0]    rf_addr_eff_s;
  logic          busy_r, busy_nxt, halt_r, halt_nxt, core_rst_r, core_rst_nxt;
  logic          rf_we_r, rf_we_nxt, mem_we_r, mem_we_nxt, mem_rd_r, mem_rd_nxt;
  logic          any_strobe_s, accept_s;
  logic [31:0]   align_data_s;

  dbg_rdata_align u_align (
    .be   (be_r),
    .word (dbg_mem_rdata),
    .data (align_data_s)
  );

  // Command qualification: armed_r requires strobes to drop between accepts so a held strobe
  // is executed exactly once even after mcu_busy falls.
  always_comb begin
    any_strobe_s  = pause | resume | reset | rf_rd | rf_wr | mem_rd | mem_wr;
    op_enc_s      = prio_encode(reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd);
    accept_s      = in_valid && any_strobe_s && armed_r && !busy_r &&
                    ((state_r == S_RUN) || (state_r == S_PAUSED));
    op_eff_s      = accept_s ? op_enc_s : op_r;
    rf_addr_eff_s = accept_s ? addr[4:0] : addr_r[4:0];
    if (accept_s) begin
      armed_nxt = 1'b0;
    end else if (!(in_valid && any_strobe_s)) begin
      armed_nxt = 1'b1;
    end else begin
      armed_nxt = armed_r;
    end
  end

  // Next-state logic and next values for every registered output.
  always_comb begin
    state_nxt   = state_r;
    paused_nxt  = paused_r;
    lat_cnt_nxt = '0;
    rst_cnt_nxt = '0;
    rdata_nxt   = rdata_r;
    case (state_r)
      S_RUN, S_PAUSED: begin
        if (accept_s) begin
          case (op_enc_s)
            OP_RESET:  state_nxt = S_RESET;
            OP_PAUSE:  state_nxt = paused_r ? S_ACK : S_DRAIN;
            OP_RESUME: begin
              paused_nxt = 1'b0;
              state_nxt  = S_ACK;
            end
            OP_MEM_WR, OP_MEM_RD: state_nxt = (paused_r && core_idle) ? S_ACC_MEM : S_DRAIN;
            OP_RF_WR, OP_RF_RD:   state_nxt = (paused_r && core_idle) ? S_ACC_RF : S_DRAIN;
            default:   state_nxt = state_r;
          endcase
        end else begin
          state_nxt = paused_r ? S_PAUSED : S_RUN;
        end
      end
      S_DRAIN: begin
        if (core_idle) begin
          case (op_r)
            OP_PAUSE: begin
              paused_nxt = 1'b1;
              state_nxt  = S_ACK;
            end
            OP_MEM_WR, OP_MEM_RD: state_nxt = S_ACC_MEM;
            OP_RF_WR, OP_RF_RD:   state_nxt = S_ACC_RF;
            default:              state_nxt = S_ACK;
          endcase
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_ACC_MEM: begin
        // Reads wait MEM_RD_LAT cycles after the strobe cycle (counter is 0 in that cycle).
        if (op_r == OP_MEM_RD) begin
          if (lat_cnt_r == LAT_C) begin
            rdata_nxt = align_data_s;
            state_nxt = S_ACK;
          end else begin
            lat_cnt_nxt = lat_cnt_r + CW'(1);
            state_nxt   = S_ACC_MEM;
          end
        end else begin
          state_nxt = S_ACK;
        end
      end
      S_ACC_RF: begin
        if (op_r == OP_RF_RD) begin
          rdata_nxt = dbg_rf_rdata;
        end else begin
          rdata_nxt = rdata_r;
        end
        state_nxt = S_ACK;
      end
      S_RESET: begin
        if (rst_cnt_r == RST_LAST_C) begin
          state_nxt = S_ACK;
        end else begin
          rst_cnt_nxt = rst_cnt_r + RW'(1);
          state_nxt   = S_RESET;
        end
      end
      S_ACK:   state_nxt = paused_r ? S_PAUSED : S_RUN;
      default: state_nxt = paused_r ? S_PAUSED : S_RUN;
    endcase

    busy_nxt     = (state_nxt != S_RUN) && (state_nxt != S_PAUSED);
    // Core is held stopped while draining or accessing, otherwise follows the paused flag.
    halt_nxt     = ((state_nxt == S_DRAIN) || (state_nxt == S_ACC_MEM) || (state_nxt == S_ACC_RF))
                   ? 1'b1 : paused_nxt;
    core_rst_nxt = (state_nxt == S_RESET);
    // Access strobes fire only on entry into the access state, giving single-cycle pulses.
    mem_we_nxt   = (state_nxt == S_ACC_MEM) && (state_r != S_ACC_MEM) && (op_eff_s == OP_MEM_WR);
    mem_rd_nxt   = (state_nxt == S_ACC_MEM) && (state_r != S_ACC_MEM) && (op_eff_s == OP_MEM_RD);
    rf_we_nxt    = (state_nxt == S_ACC_RF) && (op_eff_s == OP_RF_WR) && (rf_addr_eff_s != 5'd0);
  end

  // State, flags, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HALT_ON_RESET ? S_PAUSED : S_RUN;
      paused_r   <= HALT_ON_RESET;
      halt_r     <= HALT_ON_RESET;
      armed_r    <= 1'b1;
      lat_cnt_r  <= '0;
      rst_cnt_r  <= '0;
      rdata_r    <= 32'h0000_0000;
      busy_r     <= 1'b0;
      core_rst_r <= 1'b0;
      rf_we_r    <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_rd_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      paused_r   <= paused_nxt;
      halt_r     <= halt_nxt;
      armed_r    <= armed_nxt;
      lat_cnt_r  <= lat_cnt_nxt;
      rst_cnt_r  <= rst_cnt_nxt;
      rdata_r    <= rdata_nxt;
      busy_r     <= busy_nxt;
      core_rst_r <= core_rst_nxt;
      rf_we_r    <= rf_we_nxt;
      mem_we_r   <= mem_we_nxt;
      mem_rd_r   <= mem_rd_nxt;
    end
  end

  // Command operands latched at accept; byte writes replicate the data byte across all lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= OP_NONE;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      be_r        <= 4'b0000;
    end else if (accept_s) begin
      op_r        <= op_enc_s;
      addr_r      <= addr;
      wdata_r     <= wdata;
      mem_wdata_r <= be_is_onehot(mem_be) ? {4{wdata[7:0]}} : wdata;
      be_r        <= mem_be;
    end else begin
      op_r        <= op_r;
      addr_r      <= addr_r;
      wdata_r     <= wdata_r;
      mem_wdata_r <= mem_wdata_r;
      be_r        <= be_r;
    end
  end

  assign mcu_busy      = busy_r;
  assign rdata         = rdata_r;
  assign core_halt     = halt_r;
  assign core_reset    = core_rst_r;
  assign dbg_rf_addr   = addr_r[4:0];
  assign dbg_rf_wdata  = wdata_r;
  assign dbg_rf_we     = rf_we_r;
  assign dbg_mem_addr  = {addr_r[31:2], 2'b00};
  assign dbg_mem_wdata = mem_wdata_r;
  assign dbg_mem_be    = be_r;
  assign dbg_mem_we    = mem_we_r;
  assign dbg_mem_rd    = mem_rd_r;

endmodule

// File: doc/mcu_debug_responder.md
# mcu_debug_responder

MCU-side endpoint of the debugger command interface. It accepts the level-held command strobes issued by the debug controller (pause, resume, reset, register and memory read/write), drives the core's halt and reset inputs, and performs register-file and memory accesses through dedicated debug ports. It reports progress on a registered `mcu_busy` handshake and returns read data on `rdata`. It sits inside the MCU wrapper, between the controller's command outputs and the core, register file and memory second port.

## Interface
- `MEM_RD_LAT`, default 1: cycles from `dbg_mem_rd` to valid `dbg_mem_rdata`; must be ≥1.
- `RST_CYCLES`, default 4: number of cycles `core_reset` is held for a reset command.
- `HALT_ON_RESET`, default 0: value of the paused flag and of `core_halt` after `rst_n`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  command strobes below are qualified.
- `pause`, `resume`, `reset`, `rf_rd`, `rf_wr`, `mem_rd`, `mem_wr`  in  1 each  command strobes.
- `mem_be`  in  4  byte enables; one-hot for byte ops, `1111` for word ops.
- `addr`  in  32  memory byte address, or register index in `addr[4:0]`.
- `wdata`  in  32  write data; byte ops use `[7:0]`.
- `mcu_busy`  out  1  registered; high while a command is in progress.
- `rdata`  out  32  read result; held until the next accepted command.
- `core_halt`  out  1  asks the core to stop at the next instruction boundary.
- `core_reset`  out  1  core reset pulse.
- `core_idle`  in  1  core is stopped at an instruction boundary.
- `dbg_rf_addr`  out  5  register index.
- `dbg_rf_wdata`  out  32  register write data.
- `dbg_rf_we`  out  1  register write enable.
- `dbg_rf_rdata`  in  32  combinational register read data.
- `dbg_mem_addr`  out  32  word-aligned address: `{addr[31:2],2'b00}`.
- `dbg_mem_wdata`  out  32  memory write data.
- `dbg_mem_be`  out  4  memory byte enables.
- `dbg_mem_we`  out  1  memory write strobe.
- `dbg_mem_rd`  out  1  memory read strobe.
- `dbg_mem_rdata`  in  32  memory read data.

## Operation
- **States:** `S_RUN`, `S_PAUSED`, `S_DRAIN`, `S_ACC_MEM`, `S_ACC_RF`, `S_RESET`, `S_ACK`.
- **Persistent state:** flag `r_paused`; `core_halt = r_paused` in `S_RUN`/`S_PAUSED`, and `core_halt = 1` in `S_DRAIN`/`S_ACC_*`.
- **Accept condition:** a command is accepted only when `in_valid` is high, at least one strobe is high, and `mcu_busy` is 0 in `S_RUN` or `S_PAUSED`.
- **Strobe priority:** reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd. Lower-priority strobes in the same cycle are dropped.
- **Latching:** `addr`, `wdata`, `mem_be` and the selected op are latched at accept.
- **pause:** go to `S_DRAIN` and wait for `core_idle`, then set `r_paused=1` → `S_ACK`. If already paused, go directly to `S_ACK`.
- **resume:** set `r_paused=0` → `S_ACK`.
- **reset:** go to `S_RESET` and assert `core_reset` for `RST_CYCLES` cycles → `S_ACK`. `r_paused` is unchanged.
- **mem/rf access:** go to `S_DRAIN` (skipped if already paused and `core_idle`), then `S_ACC_MEM` or `S_ACC_RF`, then `S_ACK`. The core is re-released afterwards only if `r_paused=0`.
- **Memory write:** one cycle of `dbg_mem_we`. Byte op drives `dbg_mem_wdata = {4{wdata[7:0]}}`; word op drives `wdata`. `dbg_mem_be` = latched `mem_be`.
- **Memory read:** one cycle of `dbg_mem_rd`; data is captured `MEM_RD_LAT` cycles later.
  - One-hot `be`: `rdata` = selected byte, zero-extended.
  - Any other `be`: `rdata` = word AND lane mask.
- **Register ops:**
  - Read: `rdata = dbg_rf_rdata` in a single cycle.
  - Write: one cycle of `dbg_rf_we`.
  - Writes to x0: `dbg_rf_we` stays 0, but the command completes normally.
- **S_ACK:** `mcu_busy <= 0`, then return to `S_RUN` or `S_PAUSED` according to `r_paused`.
- **Async reset:** all outputs are 0 except `core_halt = HALT_ON_RESET`. `r_paused = HALT_ON_RESET`. State becomes `S_RUN` or `S_PAUSED`. Any in-flight access is abandoned with no partial write strobe.

## Timing
- Accept in cycle T ⇒ `mcu_busy=1` from T+1. All strobes toward the core are registered and appear no earlier than T+1.
- `mcu_busy` falls in the cycle after `S_ACK`. `rdata` is valid from that cycle onward.
- **Latency for pause when already paused, and for resume:** `mcu_busy` high for T+1 only, low at T+2.
- **Latency for rf ops from paused:** `mcu_busy` high T+1..T+2, low at T+3.
- **Latency for mem read from paused:** `mcu_busy` low at T+3+`MEM_RD_LAT`.
- **Latency for mem write from paused:** `mcu_busy` low at T+3.
- **Strobes during busy:** the controller holds strobes high while `mcu_busy`=1; these are never re-accepted.
- **Single-step:** `core_halt` is low for the cycles between resume accept and pause accept. The core leaves a boundary only when halt is sampled low there, and stops at the next boundary where halt is high.
- **Drain with no idle:** `S_DRAIN` waits indefinitely for `core_idle`; there is no timeout.

## Structure
- **Package `dbg_pkg`:**
  - state enum;
  - op enum (`OP_PAUSE` … `OP_RF_RD`);
  - strobe-priority encoder function.
- **Sub-module `dbg_rdata_align`:** combinational byte-lane select and zero-extend from `be` and the 32-bit word.
- **Read-latency counter:** width is `$clog2(MEM_RD_LAT+1)`.

## Test plan
- **Pause from running, core_idle after 3 cycles:**
  - `core_halt`=1 from T+1;
  - `mcu_busy` high T+1..T+4, low at T+5;
  - then resume: `core_halt`=0 at T'+1, busy low at T'+2.
- **Byte read while paused:** addr=0x0000_1002, be=0100, memory word 0xAABBCCDD, `MEM_RD_LAT`=2 → `dbg_mem_addr`=0x1000, `rdata`=0x0000_00BB, busy low at T+5.
- **Word mem write while running:** halt/drain first; one `dbg_mem_we` with be=1111, data 0xDEADBEEF; then `core_halt` returns to 0.
- **rf_wr to x0, then rf_rd x5 (=0x1234):**
  - `dbg_rf_we` never asserts;
  - `rdata`=0x0000_1234.
- **Simultaneous and held strobes:** pause+mem_rd in one cycle → only pause is executed. Strobes held through busy → exactly one accept.
- **Reset mid-operation:** `rst_n` low during `S_ACC_MEM` → all outputs reset immediately and no `dbg_mem_we` appears. A reset command gives `core_reset` high for exactly 4 cycles.
